s2p_rr_arbiter: RTL and testbench

- Shares one serial-to-parallel deserializer among N bit-serial requesters.
- Grants one requester for a complete FRAME_W-bit frame, using round-robin priority.
- Assembles the frame and presents it downstream with a source ID over a valid/ready handshake with backpressure.
- A per-grant idle timeout drops stalled partial frames so that one requester cannot lock the resource.

---
 rtl/s2p_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_s2p_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_rr_arbiter.sv
// Purpose     : round-robin share of one serial-to-parallel deserializer among N bit-serial requesters.
// Latency     : 1 cycle from the final accepted bit to valid_b; best-case frame period FRAME_W+2 cycles.
// Backpressure: valid_b/data_b/src_id hold while ready_b=0 and no requester is granted until handoff.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   valid_a, data_a per-requester bit-valid and serial data bit
//   ready_a         one-hot accept strobe towards the granted requester
//   valid_b, ready_b, data_b, src_id  assembled frame handshake, payload and source index
//   err_timeout     one-cycle pulse when a stalled partial frame is dropped
module s2p_rr_arbiter #(
    parameter int N       = 4,
    parameter int FRAME_W = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         valid_a,
    input  logic [N-1:0]         data_a,
    output logic [N-1:0]         ready_a,
    output logic                 valid_b,
    input  logic                 ready_b,
    output logic [FRAME_W-1:0]   data_b,
    output logic [$clog2(N)-1:0] src_id,
    output logic                 err_timeout
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(FRAME_W);

    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_W - 1);
    // Compared before the increment, so the TIMEOUT-th idle cycle fires.
    localparam logic [7:0]    IDLE_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        grant;
    logic [CW-1:0]        cnt;
    logic [7:0]           idle_cnt;
    logic [FRAME_W-1:0]   shift_reg;

    logic [IW-1:0]        pick;
    logic                 bit_in;
    logic                 accept;
    logic [FRAME_W-1:0]   frame_next;

    // Modulo-N increment that never produces an index >= N, also for
    // non-power-of-two N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Round-robin search from ptr. Walking the offsets downwards lets the
    // smallest offset with a set valid bit overwrite all others.
    always_comb begin
        pick = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_a[wrap_add(ptr, k)]) begin
                pick = wrap_add(ptr, k);
            end
        end
    end

    assign bit_in = data_a[grant];
    assign accept = (state == ST_SHIFT) && valid_a[grant] && ready_a[grant];

    // Frame including the bit being accepted this cycle, so the final bit
    // reaches data_b without an extra cycle.
    always_comb begin
        frame_next      = shift_reg;
        frame_next[cnt] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            grant       <= '0;
            cnt         <= '0;
            idle_cnt    <= '0;
            shift_reg   <= '0;
            ready_a     <= '0;
            valid_b     <= 1'b0;
            data_b      <= '0;
            src_id      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|valid_a) begin
                        grant    <= pick;
                        ready_a  <= N'(1) << pick;
                        cnt      <= '0;
                        idle_cnt <= '0;
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // An accept always wins over a coincident timeout.
                    if (accept) begin
                        shift_reg <= frame_next;
                        idle_cnt  <= '0;
                        if (cnt == CNT_LAST) begin
                            data_b  <= frame_next;
                            src_id  <= grant;
                            valid_b <= 1'b1;
                            ready_a <= '0;
                            cnt     <= '0;
                            state   <= ST_OUT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // Stalled requester: drop the partial frame and
                        // move priority past it.
                        err_timeout <= 1'b1;
                        shift_reg   <= '0;
                        cnt         <= '0;
                        idle_cnt    <= '0;
                        ready_a     <= '0;
                        ptr         <= wrap_add(grant, 1);
                        state       <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end

                ST_OUT: begin
                    if (ready_b) begin
                        valid_b <= 1'b0;
                        ptr     <= wrap_add(src_id, 1);
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_rr_arbiter.sv
// Purpose     : directed table-driven and sequence checks of s2p_rr_arbiter.
// Latency     : outputs sampled 1 time unit after each rising clock edge.
// Backpressure: ready_b driven per vector / per sequence.
module tb_s2p_rr_arbiter;

    localparam int N  = 4;
    localparam int FW = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid_a;
    logic [N-1:0]  data_a;
    logic [N-1:0]  ready_a;
    logic          valid_b;
    logic          ready_b;
    logic [FW-1:0] data_b;
    logic [1:0]    src_id;
    logic          err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    s2p_rr_arbiter #(
        .N       (N),
        .FRAME_W (FW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_a     (valid_a),
        .data_a      (data_a),
        .ready_a     (ready_a),
        .valid_b     (valid_b),
        .ready_b     (ready_b),
        .data_b      (data_b),
        .src_id      (src_id),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic          rst;
        logic [N-1:0]  va;
        logic [N-1:0]  da;
        logic          rb;
        logic [N-1:0]  ra;
        logic          vb;
        logic [FW-1:0] db;
        logic [1:0]    sid;
        logic          err;
    } vec_t;

    vec_t tbl [10];

    int ids [5];
    int exp_ids [5];
    int seen, last_cyc, bad_onehot, bad_excl, bad_gap, errs, vbs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_a = '0;
        data_a  = '0;
        ready_b = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Present bits[first .. first+count-1] on requester idx, advancing only
    // when the bit is actually accepted (ready_a seen before the edge).
    task automatic drive_bits(input int idx, input logic [FW-1:0] bits,
                              input int first, input int count);
        int   k;
        int   budget;
        logic acc;
        k      = first;
        budget = 0;
        while (k < first + count && budget < 64) begin
            valid_a[idx] = 1'b1;
            data_a[idx]  = bits[k];
            acc          = ready_a[idx];
            tick();
            if (acc) k++;
            budget++;
        end
        if (k < first + count) begin
            vectors++;
            miscompares++;
            $display("FAIL drive_bits req%0d: accepted %0d bits, required %0d", idx, k - first, count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, valid_a, data_a, ready_b | ready_a, valid_b, data_b, src_id, err
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[4] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[5] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[6] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 6'b000000, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, 6'b001101, 2'd0, 1'b0};
        tbl[8] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 6'b001101, 2'd0, 1'b0};
        tbl[9] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 6'b001101, 2'd0, 1'b0};

        exp_ids = '{0, 1, 2, 3, 0};

        rst     = 1'b1;
        valid_a = '0;
        data_a  = '0;
        ready_b = 1'b0;

        // Single requester: reset, bits 1,0,1,1,0,0, handoff, regrant of 0.
        for (int i = 0; i < 10; i++) begin
            rst     = tbl[i].rst;
            valid_a = tbl[i].va;
            data_a  = tbl[i].da;
            ready_b = tbl[i].rb;
            tick();
            chk($sformatf("vec%0d", i),
                32'({ready_a, valid_b, data_b, src_id, err_timeout}),
                32'({tbl[i].ra, tbl[i].vb, tbl[i].db, tbl[i].sid, tbl[i].err}));
        end

        // Round-robin with all requesters active and no backpressure.
        do_reset();
        valid_a    = '1;
        data_a     = '1;
        ready_b    = 1'b1;
        seen       = 0;
        last_cyc   = -1;
        bad_onehot = 0;
        bad_excl   = 0;
        bad_gap    = 0;
        for (int i = 0; i < 5; i++) ids[i] = -1;
        for (int c = 0; c < 60 && seen < 5; c++) begin
            tick();
            if (!$onehot0(ready_a)) bad_onehot++;
            if (valid_b && ready_a != '0) bad_excl++;
            if (valid_b) begin
                ids[seen] = int'(src_id);
                chk($sformatf("rr_data%0d", seen), 32'(data_b), 32'(6'b111111));
                if (last_cyc >= 0 && c - last_cyc != 8) bad_gap++;
                last_cyc = c;
                seen++;
            end
        end
        chk("rr_frames", 32'(seen), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_id%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
        chk("rr_onehot", 32'(bad_onehot), 32'd0);
        chk("rr_excl", 32'(bad_excl), 32'd0);
        chk("rr_spacing", 32'(bad_gap), 32'd0);

        // Backpressure: hold for 5 cycles, single handoff, fairness after.
        do_reset();
        valid_a = 4'b1110;
        drive_bits(0, 6'b101001, 0, 6);
        chk("bp_first", 32'({valid_b, src_id, data_b}), 32'({1'b1, 2'd0, 6'b101001}));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), 32'({ready_a, valid_b, src_id, data_b}),
                32'({4'b0000, 1'b1, 2'd0, 6'b101001}));
        end
        ready_b = 1'b1;
        tick();
        chk("bp_handoff", 32'({ready_a, valid_b, src_id, data_b}), 32'({4'b0000, 1'b0, 2'd0, 6'b101001}));
        tick();
        chk("bp_next_grant", 32'({ready_a, valid_b}), 32'({4'b0010, 1'b0}));

        // Gap tolerance on requester 2.
        do_reset();
        drive_bits(2, 6'b110010, 0, 3);
        valid_a[2] = 1'b0;
        data_a     = 4'b1111;
        errs       = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            errs += int'(err_timeout);
        end
        chk("gap_hold_ready", 32'(ready_a), 32'(4'b0100));
        drive_bits(2, 6'b110010, 3, 3);
        chk("gap_no_err", 32'(errs), 32'd0);
        chk("gap_frame", 32'({valid_b, src_id, data_b, err_timeout}), 32'({1'b1, 2'd2, 6'b110010, 1'b0}));

        // Timeout on requester 1 after 2 bits; priority moves to 2.
        do_reset();
        drive_bits(1, 6'b000011, 0, 2);
        valid_a = 4'b0100;
        errs    = 0;
        vbs     = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            errs += int'(err_timeout);
            vbs  += int'(valid_b);
        end
        chk("to_early", 32'(errs), 32'd0);
        tick();
        chk("to_pulse", 32'({err_timeout, valid_b, ready_a}), 32'({1'b1, 1'b0, 4'b0000}));
        valid_a = 4'b0110;
        tick();
        chk("to_regrant", 32'({err_timeout, valid_b, ready_a}), 32'({1'b0, 1'b0, 4'b0100}));
        chk("to_no_valid_b", 32'(vbs), 32'd0);

        // Reset in the middle of a frame from requester 3.
        do_reset();
        drive_bits(3, 6'b001111, 0, 4);
        rst     = 1'b1;
        valid_a = '0;
        tick();
        chk("rst_mid", 32'({ready_a, valid_b, data_b, src_id, err_timeout}), 32'd0);
        rst = 1'b0;
        drive_bits(3, 6'b010100, 0, 6);
        chk("rst_frame", 32'({valid_b, src_id, data_b, err_timeout}), 32'({1'b1, 2'd3, 6'b010100, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
